// File: rtl/ror_l_pkg.sv
// Shared constants for the single-position rotator: default width and
// the direction encoding used on the rr select.
package ror_l_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

endpackage

// File: rtl/ror_l_rot_stage.sv
// Combinational rotate network: fixed-wire right and left rotates by DIST,
// then a per-bit 2:1 select on the direction input.
module rot_stage
  import ror_l_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             rr_i,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH-1:0] rot_right;
  logic [WIDTH-1:0] rot_left;

  // Indices are folded at elaboration, so each bit is a plain wire.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int unsigned RightSrc = (i + DIST) % WIDTH;
    localparam int unsigned LeftSrc  = (i + WIDTH - (DIST % WIDTH)) % WIDTH;
    assign rot_right[i] = a_i[RightSrc];
    assign rot_left[i]  = a_i[LeftSrc];
  end

  always_comb begin
    r_o = rot_left;
    unique case (rr_i)
      DIR_RIGHT: r_o = rot_right;
      DIR_LEFT:  r_o = rot_left;
      default:   r_o = rot_left;
    endcase
  end

endmodule

// File: rtl/ror_l.sv
// Registered single-position bidirectional rotator: rot_stage feeding one
// output register with synchronous active-high reset.
module ror_l
  import ror_l_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DIST  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic             rr,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;

  rot_stage #(
    .WIDTH (WIDTH),
    .DIST  (DIST)
  ) u_rot_stage (
    .a_i  (a),
    .rr_i (rr),
    .r_o  (r_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign r = r_q;

endmodule

// File: tb/tb_ror_l.sv
// Directed and sweep bench for ror_l (WIDTH=8, DIST=1).
module tb_ror_l;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic       rr;
  logic [7:0] r;

  int unsigned n_checks;
  int unsigned n_errors;

  ror_l #(
    .WIDTH (8),
    .DIST  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .rr    (rr),
    .r     (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic [7:0] av, input logic rv);
    @(negedge clk);
    reset = rst;
    a     = av;
    rr    = rv;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_rot(input logic [7:0] v, input logic right);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) begin
      if (right) o[i] = v[(i + 1) % 8];
      else       o[i] = v[(i + 7) % 8];
    end
    return o;
  endfunction

  initial begin
    logic [7:0] exp_v;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    a     = 8'hA5;
    rr    = 1'b1;

    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'hA5, 1'b1);
      check_eq("reset_hold", r, 8'h00);
    end
    step(1'b0, 8'hA5, 1'b1);
    check_eq("reset_release", r, 8'hD2);

    step(1'b0, 8'b1000_0001, 1'b1);
    check_eq("ror_81", r, 8'b1100_0000);
    step(1'b0, 8'h01, 1'b1);
    check_eq("ror_01", r, 8'h80);
    step(1'b0, 8'b1000_0001, 1'b0);
    check_eq("rol_81", r, 8'b0000_0011);
    step(1'b0, 8'h80, 1'b0);
    check_eq("rol_80", r, 8'h01);
    step(1'b0, 8'h3C, 1'b0);
    check_eq("rol_3c", r, 8'h78);

    step(1'b0, 8'h00, 1'b1);
    check_eq("zero_r", r, 8'h00);
    step(1'b0, 8'h00, 1'b0);
    check_eq("zero_l", r, 8'h00);
    step(1'b0, 8'hFF, 1'b1);
    check_eq("ones_r", r, 8'hFF);
    step(1'b0, 8'hFF, 1'b0);
    check_eq("ones_l", r, 8'hFF);

    // Simultaneous change of operand and direction.
    step(1'b0, 8'h01, 1'b1);
    check_eq("simul_0", r, 8'h80);
    step(1'b0, 8'h02, 1'b0);
    check_eq("simul_1", r, 8'h04);

    // Inputs wiggling between edges must not disturb the register.
    a  = 8'h55;
    rr = 1'b1;
    #2;
    check_eq("between_edges", r, 8'h04);

    // Mid-stream reset discards the word presented on that edge.
    step(1'b0, 8'h10, 1'b1);
    check_eq("pre_midreset", r, 8'h08);
    step(1'b1, 8'h22, 1'b0);
    check_eq("midreset", r, 8'h00);
    step(1'b0, 8'h22, 1'b0);
    check_eq("post_midreset", r, 8'h44);

    // Sweep all operands, direction toggling every 256 cycles.
    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < 256; v++) begin
        step(1'b0, 8'(v), (d == 0));
        exp_v = ref_rot(8'(v), (d == 0));
        check_eq("sweep", r, exp_v);
        check_eq("popcount", 8'($countones(r)), 8'($countones(8'(v))));
      end
    end

    // Right then left returns the original word.
    step(1'b0, 8'h9B, 1'b1);
    exp_v = r;
    step(1'b0, exp_v, 1'b0);
    check_eq("inverse", r, 8'h9B);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
